// File: rtl/set_sched_pkg.sv
// rtl/set_sched_pkg.sv - shared widths and FSM state encoding for the SET job scheduler
// Purpose: operand/result field widths and the scheduler state type.
// Ports: none (package).
package set_sched_pkg;

  localparam int CENTRAL_W = 24;
  localparam int RADIUS_W  = 12;
  localparam int MODE_W    = 2;
  localparam int CAND_W    = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RUN,
    S_RESP
  } state_e;

endpackage

// File: rtl/set_rr_arbiter.sv
// rtl/set_rr_arbiter.sv - combinational round-robin pick across NREQ request bits
// Purpose: grant the first set request bit at or after ptr_i, wrapping at NREQ-1.
// Ports:
//   req_i   [NREQ-1:0] request bits
//   ptr_i   [ID_W-1:0] round-robin start position (always 0..NREQ-1)
//   grant_o [NREQ-1:0] one-hot grant, zero when no request
//   id_o    [ID_W-1:0] encoded index of the granted bit (0 when no request)
module set_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int ID_W = 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [ID_W-1:0] id_o
);

  int          idx;
  logic        found;
  logic [ID_W-1:0] cand_id;

  always_comb begin
    grant_o = '0;
    id_o    = '0;
    found   = 1'b0;
    idx     = 0;
    cand_id = '0;
    for (int k = 0; k < NREQ; k++) begin
      // ptr_i never exceeds NREQ-1, so a single subtraction wraps the index.
      idx = int'(ptr_i) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      cand_id = ID_W'(idx);
      if (!found && req_i[cand_id]) begin
        found            = 1'b1;
        grant_o[cand_id] = 1'b1;
        id_o             = cand_id;
      end
    end
  end

endmodule

// File: rtl/set_job_scheduler.sv
// rtl/set_job_scheduler.sv - round-robin front-end that sequences one SET core through issue/run/collect
// Purpose: accept one job at a time from NREQ requesters, drive the core, return the candidate count with the id.
// Optional feature: define SET_SCHED_TIMEOUT_EN to enable the RUN watchdog (TIMEOUT cycles, sets rsp_err).
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req_valid/req_ready         per-requester handshake (ready one-hot or zero, only in IDLE)
//   req_central/radius/mode     packed per-requester payloads, requester i at [W*i +: W]
//   rsp_valid/rsp_ready         result handshake; rsp_id, rsp_candidate, rsp_err held until accepted
//   core_en                     start strobe, high in ISSUE while core_busy is low
//   core_central/radius/mode    latched operands, stable from grant until the response completes
//   core_busy, core_valid       core status and 1-cycle result strobe
//   core_candidate              core result
module set_job_scheduler
  import set_sched_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int ID_W    = $clog2(NREQ),
  parameter int TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*CENTRAL_W-1:0] req_central,
  input  logic [NREQ*RADIUS_W-1:0]  req_radius,
  input  logic [NREQ*MODE_W-1:0]    req_mode,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [CAND_W-1:0]         rsp_candidate,
  output logic                      rsp_err,
  output logic                      core_en,
  output logic [CENTRAL_W-1:0]      core_central,
  output logic [RADIUS_W-1:0]       core_radius,
  output logic [MODE_W-1:0]         core_mode,
  input  logic                      core_busy,
  input  logic                      core_valid,
  input  logic [CAND_W-1:0]         core_candidate
);

  state_e               state_q, state_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [CENTRAL_W-1:0] central_q, central_d;
  logic [RADIUS_W-1:0]  radius_q, radius_d;
  logic [MODE_W-1:0]    mode_q, mode_d;
  logic [CAND_W-1:0]    cand_q, cand_d;

  logic [NREQ-1:0]      arb_grant;
  logic [ID_W-1:0]      arb_id;

`ifdef SET_SCHED_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
`endif

  set_rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (arb_grant),
    .id_o    (arb_id)
  );

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    id_d      = id_q;
    central_d = central_q;
    radius_d  = radius_q;
    mode_d    = mode_q;
    cand_d    = cand_q;
`ifdef SET_SCHED_TIMEOUT_EN
    wd_d      = wd_q;
    err_d     = err_q;
`endif
    req_ready = '0;
    core_en   = 1'b0;
    rsp_valid = 1'b0;

    case (state_q)
      S_IDLE: begin
        // The arbiter only grants set request bits, so any grant is a transfer.
        req_ready = arb_grant;
        if (|arb_grant) begin
          id_d      = arb_id;
          central_d = req_central[int'(arb_id)*CENTRAL_W +: CENTRAL_W];
          radius_d  = req_radius[int'(arb_id)*RADIUS_W +: RADIUS_W];
          mode_d    = req_mode[int'(arb_id)*MODE_W +: MODE_W];
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (core_busy) begin
          state_d = S_RUN;
`ifdef SET_SCHED_TIMEOUT_EN
          wd_d    = '0;
`endif
        end else begin
          core_en = 1'b1;
        end
      end
      S_RUN: begin
        if (core_valid) begin
          cand_d  = core_candidate;
          state_d = S_RESP;
`ifdef SET_SCHED_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          // Watchdog loses to a result arriving in the same cycle.
          cand_d  = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          wd_d    = wd_q + 1'b1;
`endif
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          rr_ptr_d = (id_q == ID_W'(NREQ - 1)) ? '0 : id_q + 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= '0;
      id_q      <= '0;
      central_q <= '0;
      radius_q  <= '0;
      mode_q    <= '0;
      cand_q    <= '0;
`ifdef SET_SCHED_TIMEOUT_EN
      wd_q      <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      id_q      <= id_d;
      central_q <= central_d;
      radius_q  <= radius_d;
      mode_q    <= mode_d;
      cand_q    <= cand_d;
`ifdef SET_SCHED_TIMEOUT_EN
      wd_q      <= wd_d;
      err_q     <= err_d;
`endif
    end
  end

  assign rsp_id        = id_q;
  assign rsp_candidate = cand_q;
  assign core_central  = central_q;
  assign core_radius   = radius_q;
  assign core_mode     = mode_q;
`ifdef SET_SCHED_TIMEOUT_EN
  assign rsp_err       = err_q;
`else
  assign rsp_err       = 1'b0;
`endif

endmodule
